// File: rtl/seg_display_if.sv
// Requester-side bundle for the seven-segment scheduler: request vector,
// the three 16-bit digit values, and the scheduled grant/value back out.
interface seg_display_if;
  logic [2:0]  req;
  logic [15:0] nums_a;
  logic [15:0] nums_b;
  logic [15:0] nums_c;
  logic [2:0]  grant;
  logic [15:0] nums;
  logic        busy;

  modport master (output req, nums_a, nums_b, nums_c,
                  input  grant, nums, busy);
  modport slave  (input  req, nums_a, nums_b, nums_c,
                  output grant, nums, busy);
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of the 4-digit display among three requesters,
// with a minimum hold per owner and a dash-pattern gap between owners.
module seg_display_scheduler #(
  parameter int          HOLD_CYCLES  = 100000000,
  parameter int          BLANK_CYCLES = 10000000,
  parameter logic [15:0] IDLE_PATTERN = 16'hFFFF,
  parameter int          CNT_W        = 27
) (
  input logic        clk,
  input logic        rst,
  seg_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic [2:0]       grant;
  logic [15:0]      nums;
  logic             busy;

  logic [1:0] p1, p2, win_idx;
  logic       win_found;

  function automatic logic [15:0] pick(input logic [1:0] idx,
                                       input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] c);
    case (idx)
      2'd0:    pick = a;
      2'd1:    pick = b;
      default: pick = c;
    endcase
  endfunction

  // Priority order last+1, last+2, last (mod 3)
  always_comb begin
    p1        = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    p2        = (p1   == 2'd2) ? 2'd0 : p1 + 2'd1;
    win_found = 1'b1;
    win_idx   = last;
    if (bus.req[p1])        win_idx = p1;
    else if (bus.req[p2])   win_idx = p2;
    else if (bus.req[last]) win_idx = last;
    else                    win_found = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 3'b000;
      nums  <= IDLE_PATTERN;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (win_found) begin
            state <= SHOW;
            grant <= 3'b001 << win_idx;
            nums  <= pick(win_idx, bus.nums_a, bus.nums_b, bus.nums_c);
            last  <= win_idx;
            busy  <= 1'b1;
          end else begin
            grant <= 3'b000;
            nums  <= IDLE_PATTERN;
            busy  <= 1'b0;
          end
        end
        SHOW: begin
          // Owner drop wins over everything, including a pending rival.
          if ((bus.req & grant) == 3'b000 ||
              (cnt == HOLD_MAX && (bus.req & ~grant) != 3'b000)) begin
            state <= BLANK;
            grant <= 3'b000;
            nums  <= IDLE_PATTERN;
            cnt   <= '0;
          end else begin
            nums <= pick(last, bus.nums_a, bus.nums_b, bus.nums_c);
            if (cnt != HOLD_MAX) cnt <= cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt == BLANK_MAX) begin
            cnt <= '0;
            if (win_found) begin
              state <= SHOW;
              grant <= 3'b001 << win_idx;
              nums  <= pick(win_idx, bus.nums_a, bus.nums_b, bus.nums_c);
              last  <= win_idx;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 3'b000;
          nums  <= IDLE_PATTERN;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.grant = grant;
  assign bus.nums  = nums;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for the display scheduler with HOLD=4, BLANK=2.
module tb_seg_display_scheduler;

  localparam logic [15:0] VA = 16'hA0A0;
  localparam logic [15:0] VB = 16'h1234;
  localparam logic [15:0] VC = 16'hC0C0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seg_display_if bus ();

  seg_display_scheduler #(
    .HOLD_CYCLES (4),
    .BLANK_CYCLES(2),
    .IDLE_PATTERN(16'hFFFF),
    .CNT_W       (27)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [15:0] v, input logic b);
    chk({tag, ".grant"}, {13'd0, bus.grant}, {13'd0, g});
    chk({tag, ".nums"},  bus.nums, v);
    chk({tag, ".busy"},  {15'd0, bus.busy}, {15'd0, b});
  endtask

  function automatic logic [15:0] val_of(input logic [2:0] g);
    case (g)
      3'b001:  val_of = VA;
      3'b010:  val_of = bus.nums_b;
      3'b100:  val_of = VC;
      default: val_of = 16'hFFFF;
    endcase
  endfunction

  task automatic do_reset(input logic [2:0] r);
    bus.req = r;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] rr_exp [19] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                              3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000,
                              3'b001};

  initial begin
    bus.req    = 3'b111;
    bus.nums_a = VA;
    bus.nums_b = VB;
    bus.nums_c = VC;

    // Reset holds off requests; requester 0 gets first priority after.
    do_reset(3'b111);
    chk_out("reset", 3'b000, 16'hFFFF, 1'b0);
    tick();
    chk_out("post_reset", 3'b001, VA, 1'b1);

    // Sole requester keeps the display indefinitely with live updates.
    do_reset(3'b000);
    bus.req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out($sformatf("single%0d", i), 3'b010, VB, 1'b1);
    end
    bus.nums_b = 16'h5678;
    tick();
    chk_out("live_update", 3'b010, 16'h5678, 1'b1);
    bus.nums_b = VB;
    tick();

    // Full round-robin with everyone asking.
    do_reset(3'b000);
    tick();
    chk_out("rr_idle", 3'b000, 16'hFFFF, 1'b0);
    bus.req = 3'b111;
    for (int i = 0; i < 19; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), rr_exp[i], val_of(rr_exp[i]), 1'b1);
    end

    // Early release after 2 SHOW cycles; requester 1 never asks.
    do_reset(3'b000);
    bus.req = 3'b101;
    tick();
    chk_out("early_show1", 3'b001, VA, 1'b1);
    tick();
    chk_out("early_show2", 3'b001, VA, 1'b1);
    bus.req = 3'b100;
    tick();
    chk_out("early_blank1", 3'b000, 16'hFFFF, 1'b1);
    tick();
    chk_out("early_blank2", 3'b000, 16'hFFFF, 1'b1);
    tick();
    chk_out("early_grant2", 3'b100, VC, 1'b1);

    // Owner drop coinciding with new requests resolves as a drop.
    bus.req = 3'b011;
    tick();
    chk_out("drop_arrive_blank", 3'b000, 16'hFFFF, 1'b1);
    bus.req = 3'b110;
    tick();
    bus.req = 3'b011;
    tick();
    chk_out("drop_arrive_grant", 3'b001, VA, 1'b1);

    // Blank then idle, then a fresh request.
    bus.req = 3'b000;
    tick();
    chk_out("bi_blank1", 3'b000, 16'hFFFF, 1'b1);
    tick();
    chk_out("bi_blank2", 3'b000, 16'hFFFF, 1'b1);
    tick();
    chk_out("bi_idle", 3'b000, 16'hFFFF, 1'b0);
    bus.req = 3'b001;
    tick();
    chk_out("bi_regrant", 3'b001, VA, 1'b1);

    // Reset mid-SHOW with requester 2 owning.
    bus.req = 3'b100;
    tick();
    tick();
    tick();
    chk_out("rs_owner2", 3'b100, VC, 1'b1);
    rst = 1'b1;
    bus.req = 3'b111;
    tick();
    chk_out("rs_show_reset", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("rs_show_after", 3'b001, VA, 1'b1);

    // Reset with requester 1 owning must restore the pointer.
    do_reset(3'b000);
    bus.req = 3'b010;
    tick();
    chk_out("rs_owner1", 3'b010, VB, 1'b1);
    rst = 1'b1;
    bus.req = 3'b111;
    tick();
    chk_out("rs_owner1_reset", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("rs_ptr", 3'b001, VA, 1'b1);

    // Reset mid-BLANK.
    bus.req = 3'b000;
    tick();
    chk_out("rb_blank", 3'b000, 16'hFFFF, 1'b1);
    rst = 1'b1;
    tick();
    chk_out("rb_reset", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    bus.req = 3'b100;
    tick();
    chk_out("rb_after", 3'b100, VC, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
